// File: rtl/valid_done_arbiter.sv
// rtl/valid_done_arbiter.sv - round-robin arbiter sharing one valid/done target between N_REQ requesters
// Optional timeout abort is enabled by defining VALID_DONE_ARBITER_TIMEOUT_EN.
module valid_done_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic [ID_W-1:0]  sel,
  input  logic             done,
  input  logic             data_ok,
  output logic             resp_valid,
  output logic [ID_W-1:0]  resp_id,
  output logic             resp_ok,
  output logic             resp_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("valid_done_arbiter: N_REQ out of range");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("valid_done_arbiter: TIMEOUT out of range");
  end

  state_t             state_q;
  logic [ID_W-1:0]    last_q;
  logic               ok_acc_q;
  logic [N_REQ-1:0]   grant_q;
  logic               valid_q;
  logic [ID_W-1:0]    sel_q;
  logic               resp_valid_q;
  logic [ID_W-1:0]    resp_id_q;
  logic               resp_ok_q;

  logic [ID_W-1:0]    next_sel_d;
  logic               req_any_d;
  logic [ID_W-1:0]    cand;

  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    next_sel_d = '0;
    req_any_d  = 1'b0;
    cand       = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = ID_W'((int'(last_q) + off) % N_REQ);
      if (req[cand]) begin
        req_any_d  = 1'b1;
        next_sel_d = cand;
      end
    end
  end

`ifdef VALID_DONE_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;
  logic       resp_timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= ID_W'(N_REQ - 1);
      ok_acc_q     <= 1'b0;
      grant_q      <= '0;
      valid_q      <= 1'b0;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_ok_q    <= 1'b0;
`ifdef VALID_DONE_ARBITER_TIMEOUT_EN
      cnt_q          <= '0;
      resp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any_d) begin
            state_q  <= S_BUSY;
            valid_q  <= 1'b1;
            sel_q    <= next_sel_d;
            grant_q  <= N_REQ'(1) << next_sel_d;
            last_q   <= next_sel_d;
            ok_acc_q <= 1'b1;
`ifdef VALID_DONE_ARBITER_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        S_BUSY: begin
          ok_acc_q <= ok_acc_q & data_ok;
          if (done) begin
            state_q      <= S_RESP;
            valid_q      <= 1'b0;
            grant_q      <= '0;
            resp_valid_q <= 1'b1;
            resp_id_q    <= sel_q;
            resp_ok_q    <= ok_acc_q & data_ok;
`ifdef VALID_DONE_ARBITER_TIMEOUT_EN
            resp_timeout_q <= 1'b0;
`endif
          end
`ifdef VALID_DONE_ARBITER_TIMEOUT_EN
          else if (cnt_q == TIMEOUT_LAST) begin
            state_q        <= S_RESP;
            valid_q        <= 1'b0;
            grant_q        <= '0;
            resp_valid_q   <= 1'b1;
            resp_id_q      <= sel_q;
            resp_ok_q      <= 1'b0;
            resp_timeout_q <= 1'b1;
          end
          cnt_q <= cnt_q + 8'd1;
`endif
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_id_q    <= '0;
          resp_ok_q    <= 1'b0;
`ifdef VALID_DONE_ARBITER_TIMEOUT_EN
          resp_timeout_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign valid      = valid_q;
  assign sel        = sel_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_ok    = resp_ok_q;
`ifdef VALID_DONE_ARBITER_TIMEOUT_EN
  assign resp_timeout = resp_timeout_q;
`else
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: doc/valid_done_arbiter.md
Name: valid_done_arbiter

Overview:
- Round-robin controller that shares one valid/done target between N_REQ requesters.
- Asserts `valid` to the target and holds it high until `done` arrives.
- Tracks whether `data_ok` stayed high on every cycle of the transaction, including the done cycle.
- Reports each transaction outcome to the granted requester through a one-cycle response strobe.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(N_REQ), width of requester index
- TIMEOUT, 16, max BUSY cycles without done before abort (2..255); used only with the optional feature

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- req  input  N_REQ  per-requester transaction request, level
- grant  output  N_REQ  one-hot owner of the target during BUSY, else 0
- valid  output  1  to target; high for the whole transaction
- sel  output  ID_W  index of current owner; valid while valid=1
- done  input  1  target completion, sampled only in BUSY
- data_ok  input  1  target data-good flag, sampled only in BUSY
- resp_valid  output  1  one-cycle completion strobe
- resp_id  output  ID_W  requester index for resp_valid, else 0
- resp_ok  output  1  1 iff data_ok was high every BUSY cycle including the done cycle
- resp_timeout  output  1  transaction aborted by timeout

Behaviour:
- Outputs are registered. Reset values:
  - grant=0, valid=0, sel=0, resp_valid=0, resp_id=0, resp_ok=0, resp_timeout=0
  - state=IDLE, round-robin pointer last=N_REQ-1, so req[0] has first priority.
- Rst in any state aborts the transaction with no response strobe; all outputs are at reset values the next cycle.
- States are IDLE, BUSY and RESP.
- IDLE:
  - If req≠0, the winner is the first set bit searching last+1, last+2, … mod N_REQ.
  - Next cycle: state=BUSY, valid=1, sel=winner, grant=1<<winner, last=winner, ok_acc=1, cnt=0.
  - If req=0, stay in IDLE.
- BUSY:
  - valid stays 1 and sel/grant stay stable regardless of req changes.
  - A requester dropping req mid-transaction does not abort it.
  - Each cycle: ok_acc &= data_ok.
  - If done=1, next cycle: state=RESP, valid=0, grant=0, resp_valid=1, resp_id=sel, resp_ok=ok_acc&data_ok, resp_timeout=0.
  - done on the first BUSY cycle is legal; this gives a single-cycle transaction.
- RESP: one cycle only; resp_* are cleared next cycle and state returns to IDLE unconditionally.
- Timing:
  - req seen in IDLE at cycle t → valid=1 at t+1.
  - done at cycle d → resp_valid=1 at d+1.
  - The next grant evaluates at d+2, with valid=1 at d+3 at the earliest.
  - valid is therefore low for at least 2 cycles between transactions.
- done or data_ok seen while not in BUSY: ignored.
- Fairness: a requester holding req continuously is granted within N_REQ transactions.

Optional Feature:
- Macro: VALID_DONE_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit cnt increments every BUSY cycle.
  - If done=0 on the BUSY cycle where cnt==TIMEOUT-1, go to RESP next cycle with resp_ok=0, resp_timeout=1, valid=0.
  - done=1 on that same cycle takes priority: normal completion, resp_timeout=0.
- Without the macro: cnt logic is absent, valid holds indefinitely until done, and resp_timeout is tied to 0.

Test Plan:
- Reset then req=4'b0001, done pulsed on 3rd BUSY cycle, data_ok=1 throughout → valid high exactly 3 cycles, grant=0001, resp_valid one cycle after done with resp_id=0, resp_ok=1.
- req=4'b1111 held, each transaction done after 1 cycle → grant order 0,1,2,3,0; resp_id matches; valid low ≥2 cycles between transactions.
- req=4'b0010, data_ok drops for one mid-transaction cycle only, done on 4th cycle with data_ok=1 → resp_ok=0; repeat with data_ok=0 only on the done cycle → resp_ok=0.
- req=4'b0100 dropped to 0 after grant, done at 5th BUSY cycle → valid held 5 cycles, grant=0100 stable, resp_id=2.
- Rst asserted during BUSY → next cycle valid=0, grant=0, no resp_valid; then req=4'b1000 → grant=1000 (pointer reset).
- TIMEOUT_EN defined, TIMEOUT=4, done never asserted → valid high 4 cycles, then resp_valid=1, resp_timeout=1, resp_ok=0. Then done on the 4th cycle → normal completion, resp_timeout=0.
